// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word and RAM status encodings,
// plus the RAM responder FSM state type and default latency.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    localparam int RAM_LAT_DEFAULT = 2;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_WAIT,
        RS_ACC,
        RS_ERR
    } ramfsm_t;

endpackage

// File: rtl/ram_responder_if.sv
// RAM-side bus between the memory controller (master)
// and the RAM responder (slave).
interface ram_responder_if;
    import cpu_types_pkg::*;

    word_t     ramaddr;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport master (
        output ramaddr, ramREN, ramWEN, ramstore,
        input  ramload, ramstate
    );

    modport slave (
        input  ramaddr, ramREN, ramWEN, ramstore,
        output ramload, ramstate
    );

endinterface

// File: rtl/ram_array.sv
// Word storage: one synchronous write port and one
// synchronous read port on a single clock, no reset.
module ram_array
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  word_t             wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output word_t             rdata_o
);

    word_t mem [2**ADDR_W];
    word_t rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// RAM responder: one word read/write at a time with LAT wait cycles.
// RAM_ADDRCHK_EN: flag out-of-range addresses as ERROR instead of wrapping.
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT    = RAM_LAT_DEFAULT,
    parameter int ADDR_W = 10
) (
    input logic            CLK,
    input logic            RST,
    ram_responder_if.slave bus
);

    localparam int CNT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_RLD = CNT_W'((LAT > 0) ? LAT - 1 : 0);

    ramfsm_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    word_t            addr_q, addr_d;
    logic             wen_q, wen_d;
    word_t            data_q, data_d;
    logic             loaded_q;

    logic  req, err, oor, chg;
    logic  acc_entry, mem_we, mem_re;
    word_t rdata;

    assign req = bus.ramREN | bus.ramWEN;

`ifdef RAM_ADDRCHK_EN
    assign oor = req & (|bus.ramaddr[31:ADDR_W+2]);
`else
    assign oor = 1'b0;
`endif

    assign err = (bus.ramREN & bus.ramWEN) | oor;
    assign chg = (bus.ramaddr != addr_q)
               | (bus.ramWEN != wen_q)
               | (bus.ramstore != data_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        data_d  = data_q;
        unique case (state_q)
            RS_IDLE: begin
                if (err) begin
                    state_d = RS_ERR;
                end else if (req) begin
                    addr_d = bus.ramaddr;
                    wen_d  = bus.ramWEN;
                    data_d = bus.ramstore;
                    if (LAT == 0) begin
                        state_d = RS_ACC;
                    end else begin
                        state_d = RS_WAIT;
                        cnt_d   = CNT_RLD;
                    end
                end
            end
            RS_WAIT: begin
                if (!req) begin
                    state_d = RS_IDLE;
                end else if (err) begin
                    state_d = RS_ERR;
                end else if (chg) begin
                    addr_d = bus.ramaddr;
                    wen_d  = bus.ramWEN;
                    data_d = bus.ramstore;
                    cnt_d  = CNT_RLD;
                end else if (cnt_q == '0) begin
                    state_d = RS_ACC;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RS_ACC: state_d = RS_IDLE;
            RS_ERR: if (!err) state_d = RS_IDLE;
            default: state_d = RS_IDLE;
        endcase
    end

    // Array is touched only on the edge that enters ACC, using the
    // next-latch values so LAT=0 requests are served straight from IDLE.
    assign acc_entry = (state_d == RS_ACC) && (state_q != RS_ACC) && !RST;
    assign mem_we    = acc_entry & wen_d;
    assign mem_re    = acc_entry & ~wen_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= RS_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            data_q   <= '0;
            loaded_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            data_q  <= data_d;
            if (mem_re) loaded_q <= 1'b1;
        end
    end

    ram_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk_i  (CLK),
        .we_i   (mem_we),
        .waddr_i(addr_d[ADDR_W+1:2]),
        .wdata_i(data_d),
        .re_i   (mem_re),
        .raddr_i(addr_d[ADDR_W+1:2]),
        .rdata_o(rdata)
    );

    // Array read register has no reset; mask it until the first read.
    assign bus.ramload = loaded_q ? rdata : '0;

    always_comb begin
        bus.ramstate = FREE;
        unique case (state_q)
            RS_IDLE: bus.ramstate = FREE;
            RS_WAIT: bus.ramstate = BUSY;
            RS_ACC:  bus.ramstate = ACCESS;
            RS_ERR:  bus.ramstate = ERROR;
            default: bus.ramstate = FREE;
        endcase
    end

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder (LAT=2 main instance, LAT=0 side instance).
module tb_ram_responder;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    ram_responder_if bus2 ();
    ram_responder_if bus0 ();

    ram_responder #(.LAT(2), .ADDR_W(10)) u_dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus2.slave)
    );

    ram_responder #(.LAT(0), .ADDR_W(10)) u_dut0 (
        .CLK(CLK),
        .RST(RST),
        .bus(bus0.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    word_t exp_q[$];

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input string tag, input word_t obs);
        if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        else chk(tag, obs, exp_q.pop_front());
    endtask

    task automatic drop2();
        bus2.ramREN = 1'b0;
        bus2.ramWEN = 1'b0;
    endtask

    // Issue one request on the LAT=2 instance and run it to ACCESS.
    task automatic access(input bit wr, input word_t a, input word_t d,
                          output int busy);
        bit got;
        @(negedge CLK);
        bus2.ramaddr  = a;
        bus2.ramstore = d;
        bus2.ramREN   = !wr;
        bus2.ramWEN   = wr;
        if (!wr) exp_q.push_back(d);
        busy = 0;
        got  = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge CLK);
            #1;
            if (bus2.ramstate == ACCESS) got = 1'b1;
            else if (bus2.ramstate == BUSY) busy++;
        end
        chk("acc_seen", word_t'(got), 32'd1);
        if (got && !wr) sb_pop("rd_data", bus2.ramload);
        @(negedge CLK);
        drop2();
        @(posedge CLK);
        #1;
        chk("free_after", word_t'(bus2.ramstate), word_t'(FREE));
    endtask

    int  busy;
    bit  got;
    word_t hold;

    initial begin
        bus2.ramaddr = '0; bus2.ramstore = '0;
        bus2.ramREN = 1'b0; bus2.ramWEN = 1'b0;
        bus0.ramaddr = '0; bus0.ramstore = '0;
        bus0.ramREN = 1'b0; bus0.ramWEN = 1'b0;

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_state", word_t'(bus2.ramstate), word_t'(FREE));
        chk("rst_load", bus2.ramload, 32'd0);
        chk("rst_state0", word_t'(bus0.ramstate), word_t'(FREE));
        @(negedge CLK);
        RST = 1'b0;

        // Write then read, latency and hold of ramload across a write
        access(1'b1, 32'h40, 32'hDEADBEEF, busy);
        chk("wr_busy", busy, 32'd2);
        access(1'b0, 32'h40, 32'hDEADBEEF, busy);
        chk("rd_busy", busy, 32'd2);
        access(1'b1, 32'h44, 32'h01020304, busy);
        chk("load_hold", bus2.ramload, 32'hDEADBEEF);

        // Mid-wait address change restarts the wait
        access(1'b1, 32'h80, 32'h11111111, busy);
        access(1'b1, 32'h84, 32'hCAFEF00D, busy);
        @(negedge CLK);
        bus2.ramaddr = 32'h80;
        bus2.ramREN  = 1'b1;
        exp_q.push_back(32'hCAFEF00D);
        @(posedge CLK);
        #1;
        chk("chg_busy1", word_t'(bus2.ramstate), word_t'(BUSY));
        @(negedge CLK);
        bus2.ramaddr = 32'h84;
        busy = 0;
        got  = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge CLK);
            #1;
            if (bus2.ramstate == ACCESS) got = 1'b1;
            else if (bus2.ramstate == BUSY) busy++;
        end
        chk("chg_acc", word_t'(got), 32'd1);
        chk("chg_busy_more", busy, 32'd2);
        if (got) sb_pop("chg_rd", bus2.ramload);
        @(negedge CLK);
        drop2();
        @(posedge CLK);
        #1;
        chk("chg_free", word_t'(bus2.ramstate), word_t'(FREE));

        // Abort after one BUSY cycle leaves memory untouched
        access(1'b1, 32'h100, 32'hAAAA5555, busy);
        @(negedge CLK);
        bus2.ramaddr  = 32'h100;
        bus2.ramstore = 32'h12345678;
        bus2.ramWEN   = 1'b1;
        @(posedge CLK);
        #1;
        chk("abt_busy", word_t'(bus2.ramstate), word_t'(BUSY));
        @(negedge CLK);
        drop2();
        @(posedge CLK);
        #1;
        chk("abt_free", word_t'(bus2.ramstate), word_t'(FREE));
        access(1'b0, 32'h100, 32'hAAAA5555, busy);

        // REN&WEN conflict
        @(negedge CLK);
        bus2.ramaddr = 32'h10;
        bus2.ramREN  = 1'b1;
        bus2.ramWEN  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            chk("conf_err", word_t'(bus2.ramstate), word_t'(ERROR));
        end
        @(negedge CLK);
        drop2();
        @(posedge CLK);
        #1;
        chk("conf_free", word_t'(bus2.ramstate), word_t'(FREE));

        // Out-of-range address
`ifdef RAM_ADDRCHK_EN
        @(negedge CLK);
        bus2.ramaddr = 32'h1000;
        bus2.ramREN  = 1'b1;
        @(posedge CLK);
        #1;
        chk("oor_err", word_t'(bus2.ramstate), word_t'(ERROR));
        @(negedge CLK);
        drop2();
        @(posedge CLK);
        #1;
        chk("oor_free", word_t'(bus2.ramstate), word_t'(FREE));
`else
        access(1'b1, 32'h1000, 32'h5A5A1234, busy);
        access(1'b0, 32'h0, 32'h5A5A1234, busy);
`endif

        // Reset in the last BUSY cycle of a write
        access(1'b1, 32'h20, 32'h0BADC0DE, busy);
        access(1'b0, 32'h20, 32'h0BADC0DE, busy);
        @(negedge CLK);
        bus2.ramaddr  = 32'h20;
        bus2.ramstore = 32'hFFFFFFFF;
        bus2.ramWEN   = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        chk("rst_busy", word_t'(bus2.ramstate), word_t'(BUSY));
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("rst_mid_free", word_t'(bus2.ramstate), word_t'(FREE));
        chk("rst_mid_load", bus2.ramload, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        drop2();
        access(1'b0, 32'h20, 32'h0BADC0DE, busy);

        // LAT=0 instance: ACCESS one cycle after the request
        @(negedge CLK);
        bus0.ramaddr  = 32'h8;
        bus0.ramstore = 32'h00000077;
        bus0.ramWEN   = 1'b1;
        @(posedge CLK);
        #1;
        chk("l0_wr_acc", word_t'(bus0.ramstate), word_t'(ACCESS));
        hold = bus0.ramload;
        @(negedge CLK);
        bus0.ramWEN = 1'b0;
        @(posedge CLK);
        #1;
        chk("l0_free", word_t'(bus0.ramstate), word_t'(FREE));
        chk("l0_wr_noload", bus0.ramload, hold);
        @(negedge CLK);
        bus0.ramREN = 1'b1;
        exp_q.push_back(32'h00000077);
        @(posedge CLK);
        #1;
        chk("l0_rd_acc", word_t'(bus0.ramstate), word_t'(ACCESS));
        sb_pop("l0_rd", bus0.ramload);
        @(negedge CLK);
        bus0.ramREN = 1'b0;
        @(posedge CLK);
        #1;
        chk("l0_free2", word_t'(bus0.ramstate), word_t'(FREE));

        chk("sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
